// File: rtl/bcd_digit_feeder.sv
// Iterative double-dabble binary-to-BCD converter feeding a 4-digit seven-segment decoder.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module bcd_digit_feeder #(
   parameter int unsigned IN_WIDTH   = 14,
   parameter logic [7:0]  BLANK_CODE = 8'd15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN_WIDTH-1:0] value_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic [3:0]          an_out,
   output logic [7:0]          dig_0_out,
   output logic [7:0]          dig_1_out,
   output logic [7:0]          dig_2_out,
   output logic [7:0]          dig_3_out,
   output logic                overflow_out,
   output logic                done_out
);

   localparam int unsigned         CNT_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam logic [IN_WIDTH-1:0] MAX_VAL  = IN_WIDTH'(9999);
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(IN_WIDTH - 1);
`ifdef BCD_LEADING_ZERO_BLANK_EN
   localparam logic [7:0]          UPPER_RST = BLANK_CODE;
`else
   localparam logic [7:0]          UPPER_RST = 8'd0;
`endif

   typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

   state_e              state_q, state_d;
   logic [IN_WIDTH-1:0] bin_q, bin_d;
   logic [15:0]         bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                load;
   logic [3:0][7:0]     dig_q, dig_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      ready_out = 1'b0;
      load      = 1'b0;
      bcd_adj   = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      unique case (state_q)
         StIdle: begin
            ready_out = 1'b1;
            if (valid_in) begin
               // Saturate so the 4-nibble accumulator can never carry out of nibble 3.
               if (value_in > MAX_VAL) begin
                  bin_d = MAX_VAL;
                  ovf_d = 1'b1;
               end else begin
                  bin_d = value_in;
                  ovf_d = 1'b0;
               end
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = StConv;
            end
         end
         StConv: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_d = StLoad;
         end
         StLoad: begin
            load    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dig_d = '0;
      for (int i = 0; i < 4; i++) dig_d[i] = {4'd0, bcd_q[4*i +: 4]};
`ifdef BCD_LEADING_ZERO_BLANK_EN
      // Blank only the zero run above the most significant non-zero digit; ones never blank.
      if (bcd_q[15:12] == 4'd0) begin
         dig_d[3] = BLANK_CODE;
         if (bcd_q[11:8] == 4'd0) begin
            dig_d[2] = BLANK_CODE;
            if (bcd_q[7:4] == 4'd0) dig_d[1] = BLANK_CODE;
         end
      end
`endif
   end

   // Display registers update only in LOAD so the shown value is stable during CONV.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dig_q        <= {UPPER_RST, UPPER_RST, UPPER_RST, 8'd0};
         overflow_out <= 1'b0;
         done_out     <= 1'b0;
      end else begin
         done_out <= load;
         if (load) begin
            dig_q        <= dig_d;
            overflow_out <= ovf_q;
         end
      end
   end

   assign an_out    = 4'b1111;
   assign dig_0_out = dig_q[0];
   assign dig_1_out = dig_q[1];
   assign dig_2_out = dig_q[2];
   assign dig_3_out = dig_q[3];

endmodule

// File: doc/bcd_digit_feeder.md
Name: bcd_digit_feeder

Overview:
- Converts an unsigned binary result from the calculator datapath into four decimal digit codes.
- Drives the digit inputs and anode-enable mask of the 4-digit seven-segment multiplexing decoder directly downstream.
- Uses an iterative shift-add-3 (double-dabble) engine with a valid/ready handshake.
- Output registers are double-buffered, so the display holds a stable value during conversion.

Parameters:
- IN_WIDTH, 14, width of the binary input; max displayable value is 9999.
- BLANK_CODE, 8'd15, digit code the downstream decoder renders with all segments off; any value outside 0..9 works.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- value_in  input  IN_WIDTH  unsigned binary value to display
- valid_in  input  1  value_in is valid; accepted when valid_in and ready_out are both 1
- ready_out  output  1  converter idle and able to accept
- an_out  output  4  anode enable mask for the decoder; constant 4'b1111, meaning all digits are multiplexed normally
- dig_0_out  output  8  ones digit code, 0..9 or BLANK_CODE
- dig_1_out  output  8  tens digit code
- dig_2_out  output  8  hundreds digit code
- dig_3_out  output  8  thousands digit code
- overflow_out  output  1  last accepted value exceeded 9999; display saturated
- done_out  output  1  one-cycle pulse when new digits are loaded

Behaviour:
- Clocking and reset
  - One clock domain.
  - reset is asynchronous and active-low.
  - Each output's reset value is listed below.
- Reset values
  - ready_out = 1, done_out = 0, overflow_out = 0, an_out = 4'b1111.
  - dig_0_out = 0.
  - dig_1_out..dig_3_out = BLANK_CODE with the optional feature, 0 without it.
- States: IDLE, CONV, LOAD.
- IDLE
  - ready_out = 1.
  - On valid_in & ready_out, capture value_in into the shift register:
    - values > 9999 are replaced by 9999, and an internal ovf flag is set;
    - otherwise ovf is cleared.
  - Clear the 16-bit BCD accumulator and the bit counter.
  - Go to CONV; ready_out drops to 0 the next cycle.
- CONV
  - Runs exactly IN_WIDTH cycles.
  - Each cycle: add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - Bit counter counts 0..IN_WIDTH-1; on the last count go to LOAD.
- LOAD (one cycle)
  - Register the nibbles into dig_*_out (zero-extended to 8 bits, after blanking if enabled).
  - Set overflow_out = ovf.
  - Pulse done_out = 1.
  - Return to IDLE.
- Latency
  - Handshake cycle T → digits and done_out visible at T + IN_WIDTH + 2 (16 cycles at default width).
  - ready_out returns to 1 in the same cycle done_out is high.
  - Throughput: one conversion per IN_WIDTH + 2 cycles.
- Hold behaviour
  - dig_*_out and overflow_out change only in LOAD.
  - The display holds the previous value throughout CONV.
- valid_in while ready_out = 0 is ignored; no queuing, no side effects.
- Back-to-back operation: valid_in held high is accepted again on the first IDLE cycle after LOAD.
- Reset asserted mid-CONV aborts the conversion; all outputs return to reset values immediately (asynchronously).
- Input 0 yields all-zero nibbles; dig_0_out is always a numeric digit, never blanked.
- Arithmetic
  - Accumulator is 16 bits (4 nibbles).
  - Saturation guarantees no carry beyond nibble 3.
  - Digits never exceed 9.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined
  - In LOAD, leading zero digits above the most significant non-zero digit are replaced with BLANK_CODE.
  - dig_0_out is never blanked.
  - Example: 42 → dig_3/2 = BLANK_CODE, dig_1 = 4, dig_0 = 2.
- Undefined
  - All four digits are always numeric (42 → 0,0,4,2).
  - Reset value of dig_1..3_out is 0.

Test Plan:
- Reset then value_in = 1234, valid_in pulse at T → at T+16: dig_3..0 = 1,2,3,4; done_out pulse 1 cycle; overflow_out = 0; ready_out = 1.
- value_in = 10000, then 16383 → each result shows 9,9,9,9 with overflow_out = 1; a following 5 → overflow_out = 0.
- value_in = 0 and value_in = 42 → with macro: BLANK×3,0 and BLANK,BLANK,4,2; without macro: 0,0,0,0 and 0,0,4,2.
- Accept 1234, then drive value_in = 5678 with valid_in high during CONV → 5678 ignored until IDLE; digits stay at the previous value until the first LOAD; then 1,2,3,4 appear; the held valid_in is accepted next and 5,6,7,8 appear 16 cycles later.
- Assert reset low at cycle 7 of CONV → outputs immediately at reset values, no done_out; after release, 9999 converts correctly to 9,9,9,9.
- Random sweep of 2000 values in 0..16383 → digits match a golden min(v,9999) decimal split; an_out constant 4'b1111.
